// File: rtl/registers_control_burst.sv
// Bridges the UART packet stream to the register bus: single/burst reads and writes,
// programmable read latency, and a saturating count of discarded packets.

package uartPackets;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

module registers_control_burst
    import uartPackets::*;
#(
    parameter int ADDR_BYTES   = 1,
    parameter int DATA_BYTES   = 4,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16
)(
    input  logic                    ipClk,
    input  logic                    ipnReset,
    input  UART_PACKET              ipRxStream,
    output UART_PACKET              opTxStream,
    input  logic                    ipTxReady,
    output logic [8*ADDR_BYTES-1:0] opAddress,
    output logic [8*DATA_BYTES-1:0] opWrData,
    output logic                    opWrEnable,
    input  logic [8*DATA_BYTES-1:0] ipRdData,
    output logic [7:0]              opErrorCount
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = AW + DW;

    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_CNT, RX_DATA, DISCARD, RD_WAIT, TX} tState;

    tState         state, nextState, ctx;
    logic [7:0]    rxCount, rxLength, txDest, txLength, wordsLeft, wordByte, txLeft;
    logic          isWrite, txFirst;
    logic [AW-1:0] addrShift;
    logic [DW-1:0] wordShift;
    logic [TW-1:0] txBuf;
    logic [3:0]    latCnt;

    logic          startPkt, pktWrite, headerBad, lengthBad;
    logic [8:0]    byteCount, errSum;
    logic [7:0]    pktLength, burstWords;
    logic [1:0]    errInc;
    logic          shiftAddr, addrDone, loadRead, shiftData, wordDone, capture, txFire, nextWord;

    assign errSum = {1'b0, opErrorCount} + {7'b0, errInc};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nextState  = state;
        errInc     = 2'd0;
        shiftAddr  = 1'b0;
        addrDone   = 1'b0;
        loadRead   = 1'b0;
        burstWords = 8'd1;
        shiftData  = 1'b0;
        wordDone   = 1'b0;
        capture    = 1'b0;
        txFire     = 1'b0;
        nextWord   = 1'b0;
        opTxStream = '0;

        // A SoP outside RD_WAIT/TX (re)starts parsing; its byte is handled as an address byte.
        startPkt  = ipRxStream.Valid && ipRxStream.SoP && !(state inside {RD_WAIT, TX});
        ctx       = startPkt ? RX_ADDR : state;
        pktLength = startPkt ? ipRxStream.Length : rxLength;
        pktWrite  = startPkt ? (ipRxStream.Destination == 8'h01) : isWrite;
        byteCount = startPkt ? 9'd1 : {1'b0, rxCount} + 9'd1;
        lengthBad = ipRxStream.EoP != (byteCount == {1'b0, pktLength});

        headerBad = 1'b1;
        if (ipRxStream.Destination == 8'h00)
            headerBad = !(int'(pktLength) == ADDR_BYTES || int'(pktLength) == ADDR_BYTES + 1);
        else if (ipRxStream.Destination == 8'h01)
            headerBad = int'(pktLength) < ADDR_BYTES + DATA_BYTES ||
                        (int'(pktLength) - ADDR_BYTES) % DATA_BYTES != 0;

        if (ipRxStream.Valid) begin
            if (ipRxStream.SoP && (state inside {RX_ADDR, RX_CNT, RX_DATA, RD_WAIT, TX}))
                errInc = 2'd1;
            if (startPkt || (state inside {RX_ADDR, RX_CNT, RX_DATA})) begin
                if ((startPkt && headerBad) || lengthBad) begin
                    errInc    = errInc + 2'd1;
                    nextState = ipRxStream.EoP ? IDLE : DISCARD;
                end else begin
                    case (ctx)
                        RX_ADDR: begin
                            shiftAddr = 1'b1;
                            nextState = RX_ADDR;
                            if (byteCount == 9'(ADDR_BYTES)) begin
                                addrDone = 1'b1;
                                if (pktWrite)
                                    nextState = RX_DATA;
                                else if (ipRxStream.EoP) begin
                                    nextState = RD_WAIT;
                                    loadRead  = 1'b1;
                                end else
                                    nextState = RX_CNT;
                            end
                        end
                        RX_CNT: begin
                            if (ipRxStream.Data == 8'd0 || int'(ipRxStream.Data) > MAX_BURST) begin
                                errInc    = errInc + 2'd1;
                                nextState = ipRxStream.EoP ? IDLE : DISCARD;
                            end else begin
                                loadRead   = 1'b1;
                                burstWords = ipRxStream.Data;
                                nextState  = RD_WAIT;
                            end
                        end
                        RX_DATA: begin
                            shiftData = 1'b1;
                            wordDone  = wordByte == 8'(DATA_BYTES - 1);
                            if (ipRxStream.EoP)
                                nextState = IDLE;
                        end
                        default: ;
                    endcase
                end
            end else if (state == DISCARD && ipRxStream.EoP)
                nextState = IDLE;
        end

        case (state)
            RD_WAIT: begin
                if (latCnt == 4'(READ_LATENCY - 1)) begin
                    capture   = 1'b1;
                    nextState = TX;
                end
            end
            TX: begin
                opTxStream.Destination = txDest;
                opTxStream.Length      = txLength;
                opTxStream.Data        = txBuf[TW-1 -: 8];
                opTxStream.SoP         = txFirst;
                opTxStream.EoP         = (wordsLeft == 8'd1) && (txLeft == 8'd1);
                opTxStream.Valid       = 1'b1;
                if (ipTxReady) begin
                    txFire = 1'b1;
                    if (txLeft == 8'd1) begin
                        if (wordsLeft == 8'd1)
                            nextState = IDLE;
                        else begin
                            nextWord  = 1'b1;
                            nextState = RD_WAIT;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values.
        if (!ipnReset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            rxCount      <= '0;
            rxLength     <= '0;
            isWrite      <= 1'b0;
            txDest       <= '0;
            txLength     <= '0;
            wordsLeft    <= '0;
            wordByte     <= '0;
            txLeft       <= '0;
            txFirst      <= 1'b0;
            addrShift    <= '0;
            wordShift    <= '0;
            txBuf        <= '0;
            latCnt       <= '0;
            opAddress    <= '0;
            opWrData     <= '0;
            opWrEnable   <= 1'b0;
            opErrorCount <= '0;
        end else begin
            if (startPkt) begin
                rxLength <= ipRxStream.Length;
                txDest   <= ipRxStream.Source;
                isWrite  <= ipRxStream.Destination == 8'h01;
            end
            if (ipRxStream.Valid && (startPkt || (state inside {RX_ADDR, RX_CNT, RX_DATA})))
                rxCount <= byteCount[7:0];
            if (shiftAddr)
                addrShift <= AW'({addrShift, ipRxStream.Data});

            // A strobe only follows a fully received, in-length word.
            opWrEnable <= wordDone;
            if (wordDone)
                opWrData <= DW'({wordShift, ipRxStream.Data});
            if (shiftData)
                wordShift <= DW'({wordShift, ipRxStream.Data});
            if (addrDone)
                wordByte <= '0;
            else if (shiftData)
                wordByte <= wordDone ? 8'd0 : wordByte + 8'd1;

            if (addrDone)
                opAddress <= AW'({addrShift, ipRxStream.Data});
            else if (opWrEnable || nextWord)
                opAddress <= opAddress + 1'b1;

            if (loadRead) begin
                wordsLeft <= burstWords;
                txLength  <= 8'(ADDR_BYTES + int'(burstWords) * DATA_BYTES);
                txFirst   <= 1'b1;
            end
            latCnt <= (state == RD_WAIT) ? latCnt + 4'd1 : 4'd0;

            if (capture) begin
                txBuf  <= txFirst ? {addrShift, ipRdData} : {ipRdData, {AW{1'b0}}};
                txLeft <= txFirst ? 8'(ADDR_BYTES + DATA_BYTES) : 8'(DATA_BYTES);
            end else if (txFire) begin
                txBuf   <= txBuf << 8;
                txLeft  <= txLeft - 8'd1;
                txFirst <= 1'b0;
            end
            if (nextWord)
                wordsLeft <= wordsLeft - 8'd1;

            opErrorCount <= errSum[8] ? 8'hFF : errSum[7:0];
        end
    end
endmodule

// File: tb/tb_registers_control_burst.sv
// Directed bench for registers_control_burst: single and burst reads/writes, address wrap,
// transmit backpressure, error counting with saturation, and reset during a response.
module tb_registers_control_burst;
    import uartPackets::*;

    logic        ipClk = 1'b0;
    logic        ipnReset = 1'b0;
    logic        ipTxReady = 1'b0;
    logic        opWrEnable;
    UART_PACKET  ipRxStream, opTxStream, snapshot;
    logic [7:0]  opAddress, opErrorCount;
    logic [31:0] opWrData, ipRdData;

    int          vectorCount = 0;
    int          missCount = 0;
    int          holdChanges;
    UART_PACKET  txQ[$];
    logic [39:0] wrQ[$];
    logic [7:0]  payload[$];
    logic [7:0]  expBytes[$];

    always #5 ipClk = ~ipClk;

    // Register file model: the read word embeds the address it was read from.
    assign ipRdData = {16'h1234, opAddress, 8'hAB};

    registers_control_burst dut (
        .ipClk        (ipClk),
        .ipnReset     (ipnReset),
        .ipRxStream   (ipRxStream),
        .opTxStream   (opTxStream),
        .ipTxReady    (ipTxReady),
        .opAddress    (opAddress),
        .opWrData     (opWrData),
        .opWrEnable   (opWrEnable),
        .ipRdData     (ipRdData),
        .opErrorCount (opErrorCount)
    );

    always @(negedge ipClk) begin
        if (opTxStream.Valid && ipTxReady)
            txQ.push_back(opTxStream);
        if (opWrEnable)
            wrQ.push_back({opAddress, opWrData});
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic sendPacket(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
        for (int i = 0; i < payload.size(); i++) begin
            ipRxStream.Source      = src;
            ipRxStream.Destination = dst;
            ipRxStream.Length      = len;
            ipRxStream.Data        = payload[i];
            ipRxStream.SoP         = (i == 0);
            ipRxStream.EoP         = (i == payload.size() - 1);
            ipRxStream.Valid       = 1'b1;
            @(posedge ipClk); #1;
        end
        ipRxStream = '0;
    endtask

    task automatic waitTx(input string tag, input int n);
        int budget = 400;
        while (txQ.size() < n && budget > 0) begin
            @(posedge ipClk);
            budget--;
        end
        repeat (3) @(posedge ipClk);
        #1;
        check(tag, 64'(txQ.size()), 64'(n));
    endtask

    task automatic waitValid(input string tag);
        int budget = 50;
        while (!opTxStream.Valid && budget > 0) begin
            @(negedge ipClk);
            budget--;
        end
        check(tag, 64'(opTxStream.Valid), 64'd1);
        @(posedge ipClk); #1;
    endtask

    task automatic checkTx(input string tag, input logic [7:0] dest, input logic [7:0] len);
        for (int i = 0; i < expBytes.size() && i < txQ.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(txQ[i].Data), 64'(expBytes[i]));
            check($sformatf("%s_hdr%0d", tag, i),
                  64'({txQ[i].Source, txQ[i].Destination, txQ[i].Length, txQ[i].SoP, txQ[i].EoP}),
                  64'({8'h00, dest, len, i == 0, i == expBytes.size() - 1}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ipRxStream = '0;
        repeat (3) @(posedge ipClk);
        #1;
        check("reset_tx",    64'(opTxStream),   64'd0);
        check("reset_wren",  64'(opWrEnable),   64'd0);
        check("reset_addr",  64'(opAddress),    64'd0);
        check("reset_wdata", 64'(opWrData),     64'd0);
        check("reset_err",   64'(opErrorCount), 64'd0);
        ipnReset = 1'b1;
        repeat (2) @(posedge ipClk);
        #1;

        // Single read at latency 1
        ipTxReady = 1'b1;
        payload = '{8'h12};
        sendPacket(8'hAA, 8'h00, 8'd1);
        waitTx("rd1_count", 5);
        expBytes = '{8'h12, 8'h12, 8'h34, 8'h12, 8'hAB};
        checkTx("rd1", 8'hAA, 8'd5);
        check("rd1_nowrite", 64'(wrQ.size()), 64'd0);

        // Single write
        txQ.delete(); wrQ.delete();
        payload = '{8'h12, 8'h17, 8'h1C, 8'h21, 8'h26};
        sendPacket(8'h5A, 8'h01, 8'd5);
        repeat (5) @(posedge ipClk);
        #1;
        check("wr1_count", 64'(wrQ.size()), 64'd1);
        if (wrQ.size() >= 1) check("wr1_word", 64'(wrQ[0]), 64'h12_171C2126);
        check("wr1_notx", 64'(txQ.size()), 64'd0);

        // Burst write of two words
        wrQ.delete();
        payload = '{8'h40, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        sendPacket(8'h5A, 8'h01, 8'd9);
        repeat (5) @(posedge ipClk);
        #1;
        check("bwr_count", 64'(wrQ.size()), 64'd2);
        if (wrQ.size() >= 2) begin
            check("bwr_word0", 64'(wrQ[0]), 64'h40_11111111);
            check("bwr_word1", 64'(wrQ[1]), 64'h41_22222222);
        end

        // Burst read of 3 words wrapping past 0xFF
        txQ.delete(); wrQ.delete();
        payload = '{8'hFE, 8'h03};
        sendPacket(8'h3C, 8'h00, 8'd2);
        waitTx("brd_count", 13);
        expBytes = '{8'hFE, 8'h12, 8'h34, 8'hFE, 8'hAB, 8'h12, 8'h34, 8'hFF, 8'hAB,
                     8'h12, 8'h34, 8'h00, 8'hAB};
        checkTx("brd", 8'h3C, 8'd13);

        // Backpressure after two bytes for 100 cycles
        txQ.delete();
        payload = '{8'h55};
        sendPacket(8'hAA, 8'h00, 8'd1);
        for (int budget = 0; budget < 50 && txQ.size() < 2; budget++)
            @(posedge ipClk);
        #1;
        ipTxReady = 1'b0;
        @(negedge ipClk);
        snapshot = opTxStream;
        check("bp_valid", 64'(snapshot.Valid), 64'd1);
        holdChanges = 0;
        repeat (100) begin
            @(negedge ipClk);
            if (opTxStream !== snapshot) holdChanges++;
        end
        check("bp_hold", 64'(holdChanges), 64'd0);
        @(posedge ipClk); #1;
        ipTxReady = 1'b1;
        waitTx("bp_count", 5);
        expBytes = '{8'h55, 8'h12, 8'h34, 8'h55, 8'hAB};
        checkTx("bp", 8'hAA, 8'd5);

        // Early EoP, unknown command, and read SoP during TX
        txQ.delete(); wrQ.delete();
        payload = '{8'h30, 8'hAA, 8'hBB};
        sendPacket(8'hAA, 8'h01, 8'd9);
        payload = '{8'h55};
        sendPacket(8'hAA, 8'h07, 8'd1);
        ipTxReady = 1'b0;
        payload = '{8'h20};
        sendPacket(8'hAA, 8'h00, 8'd1);
        waitValid("err_tx_up");
        payload = '{8'h21};
        sendPacket(8'hBB, 8'h00, 8'd1);
        ipTxReady = 1'b1;
        waitTx("err_tx_count", 5);
        expBytes = '{8'h20, 8'h12, 8'h34, 8'h20, 8'hAB};
        checkTx("err_tx", 8'hAA, 8'd5);
        repeat (10) @(posedge ipClk);
        #1;
        check("err_no_extra_tx", 64'(txQ.size()), 64'd5);
        check("err_count3",      64'(opErrorCount), 64'd3);
        check("err_no_strobe",   64'(wrQ.size()), 64'd0);

        // Error counter saturation
        payload = '{8'h00};
        repeat (300) sendPacket(8'hAA, 8'h07, 8'd1);
        repeat (2) @(posedge ipClk);
        #1;
        check("err_saturate", 64'(opErrorCount), 64'd255);

        // Reset during a stalled response
        txQ.delete();
        ipTxReady = 1'b0;
        payload = '{8'h44};
        sendPacket(8'hAA, 8'h00, 8'd1);
        waitValid("rst_tx_up");
        ipnReset = 1'b0;
        #1;
        check("rst_tx_clear", 64'(opTxStream),   64'd0);
        check("rst_err",      64'(opErrorCount), 64'd0);
        @(posedge ipClk); #1;
        ipnReset = 1'b1;
        repeat (5) @(posedge ipClk);
        #1;
        check("rst_idle", 64'(opTxStream.Valid), 64'd0);
        ipTxReady = 1'b1;
        payload = '{8'h66};
        sendPacket(8'hAA, 8'h00, 8'd1);
        waitTx("rst_rd_count", 5);
        expBytes = '{8'h66, 8'h12, 8'h34, 8'h66, 8'hAB};
        checkTx("rst_rd", 8'hAA, 8'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
